// File: rtl/regfile_write_sequencer_if.sv
// Bus bundle for regfile_write_sequencer.
// slave  : the sequencer side (decoded instruction, data and status in; phase,
//          effective address, FSR shadow, GPR/STATUS write ports and skip out).
// master : the core/bench side driving the instruction and data inputs.
interface regfile_write_sequencer_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int FILE_ADDR_WIDTH = 5,
  parameter int BANK_BITS       = 2
);
  localparam int A = FILE_ADDR_WIDTH + BANK_BITS;

  logic                       stall;
  logic                       instValid;
  logic [2:0]                 opClass;
  logic                       destF;
  logic [FILE_ADDR_WIDTH-1:0] fileAddr;
  logic [DATA_WIDTH-1:0]      wRIn;
  logic [DATA_WIDTH-1:0]      aluResultIn;
  logic [2:0]                 aluStatusIn;
  logic [2:0]                 aluFlagMask;
  logic [DATA_WIDTH-1:0]      statusIn;

  logic [1:0]                 qPhase;
  logic [A-1:0]               effAddrOut;
  logic [A-1:0]               fsrOut;
  logic                       gprWrEn;
  logic [A-1:0]               gprWrAddr;
  logic [DATA_WIDTH-1:0]      gprWrData;
  logic                       statusWrEn;
  logic [DATA_WIDTH-1:0]      statusWrData;
  logic                       skipOut;

  modport master (
    output stall, instValid, opClass, destF, fileAddr, wRIn, aluResultIn,
           aluStatusIn, aluFlagMask, statusIn,
    input  qPhase, effAddrOut, fsrOut, gprWrEn, gprWrAddr, gprWrData,
           statusWrEn, statusWrData, skipOut
  );

  modport slave (
    input  stall, instValid, opClass, destF, fileAddr, wRIn, aluResultIn,
           aluStatusIn, aluFlagMask, statusIn,
    output qPhase, effAddrOut, fsrOut, gprWrEn, gprWrAddr, gprWrData,
           statusWrEn, statusWrData, skipOut
  );
endinterface

// File: rtl/regfile_write_sequencer.sv
// Registered register-file write sequencer for a PIC16C5x-style core.
// Owns the Q1..Q4 phase counter and the FSR shadow, resolves direct, banked
// and indirect effective addresses, and produces one-cycle GPR/STATUS write
// strobes plus a skip request in Q4.
// Ports:
//   clk  - core clock
//   rst  - synchronous active-high reset
//   bus  - regfile_write_sequencer_if.slave (instruction/data in, write ports out)
module regfile_write_sequencer #(
  parameter int DATA_WIDTH      = 8,
  parameter int FILE_ADDR_WIDTH = 5,
  parameter int BANK_BITS       = 2,
  parameter int STATUS_ADDR     = 3,
  parameter int FSR_ADDR        = 4
) (
  input logic                     clk,
  input logic                     rst,
  regfile_write_sequencer_if.slave bus
);
  localparam int F = FILE_ADDR_WIDTH;
  localparam int A = FILE_ADDR_WIDTH + BANK_BITS;

  localparam logic [1:0] Q1 = 2'd0;
  localparam logic [1:0] Q2 = 2'd1;
  localparam logic [1:0] Q3 = 2'd2;
  localparam logic [1:0] Q4 = 2'd3;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CLRF   = 3'd1;
  localparam logic [2:0] OP_CLRW   = 3'd2;
  localparam logic [2:0] OP_MOVWF  = 3'd3;
  localparam logic [2:0] OP_BXF    = 3'd4;
  localparam logic [2:0] OP_FSZ    = 3'd5;
  localparam logic [2:0] OP_ALU    = 3'd6;
  localparam logic [2:0] OP_ALUXLW = 3'd7;

  logic [1:0]            phase_q;
  logic [2:0]            op_q;
  logic                  destF_q;
  logic [F-1:0]          fileAddr_q;
  logic [2:0]            mask_q;
  logic [A-1:0]          effAddr_q;
  logic [A-1:0]          fsr_q;
  logic [A-1:0]          gprWrAddr_q;
  logic [DATA_WIDTH-1:0] gprWrData_q;
  logic                  gprPend_q;
  logic                  statusPend_q;
  logic [DATA_WIDTH-1:0] statusWrData_q;
  logic                  skipPend_q;

  logic [A-1:0]          src;
  logic [A-1:0]          effAddr_d;
  logic [DATA_WIDTH-1:0] wrData_d;
  logic [DATA_WIDTH-1:0] base;
  logic [DATA_WIDTH-1:0] statusWrData_d;
  logic [2:0]            upd;
  logic [2:0]            flags;
  logic                  fileWr;
  logic                  statusHit;
  logic                  nullInd;
  logic                  gprWrEn_d;
  logic                  statusWrEn_d;
  logic                  skip_d;
  logic                  commit;

  // Address 0 selects INDF (indirect through FSR). Only the upper half of a
  // bank is banked; the lower half always aliases bank 0.
  always_comb begin
    src = (fileAddr_q == '0) ? fsr_q : {{BANK_BITS{1'b0}}, fileAddr_q};
    if (src[F-1]) effAddr_d = {fsr_q[A-1:F], src[F-1:0]};
    else          effAddr_d = {{BANK_BITS{1'b0}}, src[F-1:0]};
  end

  always_comb begin
    wrData_d = bus.aluResultIn;
    fileWr   = 1'b0;
    upd      = '0;
    flags    = '0;
    skip_d   = 1'b0;
    case (op_q)
      OP_CLRF: begin
        wrData_d = '0;
        fileWr   = 1'b1;
        upd      = 3'b100;
        flags    = 3'b100;
      end
      OP_CLRW: begin
        wrData_d = '0;
        upd      = 3'b100;
        flags    = 3'b100;
      end
      OP_MOVWF: begin
        wrData_d = bus.wRIn;
        fileWr   = 1'b1;
      end
      OP_BXF: fileWr = 1'b1;
      OP_FSZ: begin
        fileWr = destF_q;
        skip_d = (bus.aluResultIn == '0);
      end
      OP_ALU: begin
        fileWr = destF_q;
        upd    = mask_q;
        flags  = bus.aluStatusIn;
      end
      OP_ALUXLW: begin
        upd   = mask_q;
        flags = bus.aluStatusIn;
      end
      default: ;
    endcase

    // E[F-1:0]==0 can only arise from INDF-through-INDF, since a direct
    // address of 0 is itself the indirect selector.
    statusHit    = (effAddr_q[F-1:0] == F'(STATUS_ADDR));
    nullInd      = (effAddr_q[F-1:0] == '0);
    gprWrEn_d    = fileWr & ~statusHit & ~nullInd;
    statusWrEn_d = (|upd) | (fileWr & statusHit);

    // A file write aimed at STATUS becomes the merge base; op flags still win
    // on the bits they update.
    base           = (fileWr & statusHit) ? wrData_d : bus.statusIn;
    statusWrData_d = base;
    statusWrData_d[2:0] = (base[2:0] & ~upd) | (flags & upd);
  end

  assign commit = (phase_q == Q4) & ~bus.stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q        <= Q1;
      op_q           <= OP_NOP;
      destF_q        <= 1'b0;
      fileAddr_q     <= '0;
      mask_q         <= '0;
      effAddr_q      <= '0;
      fsr_q          <= '0;
      gprWrAddr_q    <= '0;
      gprWrData_q    <= '0;
      gprPend_q      <= 1'b0;
      statusPend_q   <= 1'b0;
      statusWrData_q <= '0;
      skipPend_q     <= 1'b0;
    end else if (!bus.stall) begin
      phase_q <= phase_q + 2'd1;
      case (phase_q)
        Q1: begin
          op_q       <= bus.instValid ? bus.opClass : OP_NOP;
          destF_q    <= bus.destF;
          fileAddr_q <= bus.fileAddr;
          mask_q     <= bus.aluFlagMask;
        end
        Q2: effAddr_q <= effAddr_d;
        Q3: begin
          gprWrAddr_q    <= effAddr_q;
          gprWrData_q    <= wrData_d;
          gprPend_q      <= gprWrEn_d;
          statusPend_q   <= statusWrEn_d;
          statusWrData_q <= statusWrData_d;
          skipPend_q     <= skip_d;
        end
        default: begin
          gprPend_q    <= 1'b0;
          statusPend_q <= 1'b0;
          skipPend_q   <= 1'b0;
          if (gprPend_q && (gprWrAddr_q[F-1:0] == F'(FSR_ADDR)))
            fsr_q <= A'(gprWrData_q);
        end
      endcase
    end
  end

  // Pending strobes are only exposed in an unstalled Q4, so a stalled Q4
  // shows them low and the commit happens on the first free edge.
  assign bus.qPhase       = phase_q;
  assign bus.effAddrOut   = effAddr_q;
  assign bus.fsrOut       = fsr_q;
  assign bus.gprWrEn      = gprPend_q & commit;
  assign bus.gprWrAddr    = gprWrAddr_q;
  assign bus.gprWrData    = gprWrData_q;
  assign bus.statusWrEn   = statusPend_q & commit;
  assign bus.statusWrData = statusWrData_q;
  assign bus.skipOut      = skipPend_q & commit;
endmodule
